led_rom_sequencer: RTL and testbench

Read-side sequencer for the LED pattern block-RAM ROMs (4-bit pattern, 12-bit word address, one-cycle synchronous read). It divides the 200 MHz clock down to a visible step rate and walks the ROM address up (left shift) or down (right shift). It enables the ROM port, captures the returned pattern after the read latency, and drives the registered LED outputs. It sits between the board-level run/direction controls and the pattern ROM instance.

---
 rtl/led_pkg.sv | 19 +
 rtl/led_rom_sequencer_if.sv | 12 +
 rtl/led_prescaler.sv | 32 +++
 rtl/led_rom_sequencer.sv | 96 +++++++++
 tb/tb_led_rom_sequencer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern ROM read path and its ROM wrappers.
package led_pkg;

   localparam int ADDR_W = 12;           // ROM word-address width
   localparam int DATA_W = 4;            // ROM data / LED width
   localparam int CLK_HZ = 200_000_000;  // board clock

   localparam logic DIR_LEFT  = 1'b0;    // address +1
   localparam logic DIR_RIGHT = 1'b1;    // address -1

   typedef enum logic [2:0] {
      IDLE,
      PRIME,
      WAIT,
      FETCH,
      CAPTURE
   } state_t;

endpackage

// File: rtl/led_rom_sequencer_if.sv
// Read port between the sequencer (master) and a pattern ROM (slave).
interface led_rom_sequencer_if;
   import led_pkg::*;

   logic              rom_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;

   modport master (output rom_en, output rom_addr, input rom_data);
   modport slave  (input rom_en, input rom_addr, output rom_data);

endinterface

// File: rtl/led_prescaler.sv
// Step-rate divider: tick marks the last of PRESCALE counted cycles.
module led_prescaler #(
   parameter int PRESCALE = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic count_en,
   output logic tick
);

   localparam int               CNT_W = $clog2(PRESCALE);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] count;

   // The count only reaches LAST by counting, so the tick that follows still
   // fires if count_en drops on that cycle.
   assign tick = (count == LAST);

   // Counter: wraps on tick, advances when enabled, otherwise holds.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop in
      // the design samples pre-edge values, independent of process order.
      if (rst)
         count <= '0;
      else if (tick)
         count <= '0;
      else if (count_en)
         count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/led_rom_sequencer.sv
// Walks the LED pattern ROM one address per step and latches the returned
// pattern onto the LED outputs.
module led_rom_sequencer
   import led_pkg::*;
#(
   parameter int PRESCALE  = 50_000_000,
   parameter int ADDR_LAST = 4095
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     run,
   input  logic                     dir,
   led_rom_sequencer_if.master      rom,
   output logic [DATA_W-1:0]        led,
   output logic                     step_pulse
);

   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(ADDR_LAST);

   state_t            state, state_nx;
   logic              tick;
   logic              rom_en_nx;
   logic [ADDR_W-1:0] rom_addr_nx;
   logic [DATA_W-1:0] led_nx;
   logic              step_nx;

   // Neighbouring address with explicit wrap at 0 and ADDR_LAST.
   function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                   input logic              d);
      if (d == DIR_LEFT)
         return (a == LAST_A) ? '0 : a + ADDR_W'(1);
      else
         return (a == '0) ? LAST_A : a - ADDR_W'(1);
   endfunction

   // The step period is counted only while waiting with stepping enabled.
   led_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .count_en (run && (state == WAIT)),
      .tick     (tick)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Next state: PRIME/CAPTURE show the start address, WAIT/FETCH/CAPTURE step.
   always_comb begin
      // NOTE: defaulting every combinational output first prevents latches
      // on paths that do not assign it.
      state_nx = state;
      unique case (state)
         IDLE:    if (run) state_nx = PRIME;
         PRIME:   state_nx = CAPTURE;
         WAIT:    if (tick) state_nx = FETCH;
         FETCH:   state_nx = CAPTURE;
         CAPTURE: state_nx = WAIT;
         default: state_nx = IDLE;
      endcase
   end

   // Output values for the next edge; dir only matters on the tick edge.
   always_comb begin
      rom_en_nx   = (state_nx != IDLE);
      rom_addr_nx = rom.rom_addr;
      led_nx      = led;
      step_nx     = 1'b0;
      if ((state == WAIT) && tick)
         rom_addr_nx = step_addr(rom.rom_addr, dir);
      if (state == CAPTURE) begin
         led_nx  = rom.rom_data;
         step_nx = 1'b1;
      end
   end

   // Registered outputs, cleared asynchronously by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rom.rom_en   <= 1'b0;
         rom.rom_addr <= '0;
         led          <= '0;
         step_pulse   <= 1'b0;
      end else begin
         rom.rom_en   <= rom_en_nx;
         rom.rom_addr <= rom_addr_nx;
         led          <= led_nx;
         step_pulse   <= step_nx;
      end
   end

endmodule

// File: tb/tb_led_rom_sequencer.sv
// Self-checking bench for led_rom_sequencer with PRESCALE=4, ADDR_LAST=7.
module tb_led_rom_sequencer;
   import led_pkg::*;

   localparam int PRESCALE  = 4;
   localparam int ADDR_LAST = 7;
   localparam int STEP      = PRESCALE + 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              run = 1'b0;
   logic              dir = 1'b0;
   logic [DATA_W-1:0] led;
   logic              step_pulse;

   led_rom_sequencer_if rom_if ();

   int errors     = 0;
   int checks     = 0;
   int cyc        = 0;
   int last_pulse = 0;
   int model_addr = 0;

   led_rom_sequencer #(.PRESCALE(PRESCALE), .ADDR_LAST(ADDR_LAST)) dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .dir        (dir),
      .rom        (rom_if.master),
      .led        (led),
      .step_pulse (step_pulse)
   );

   always #5 clk = ~clk;

   // Pattern ROM: one-cycle synchronous read, data = 1 << (addr mod 4).
   always @(posedge clk)
      rom_if.rom_data <= rom_if.rom_en ? (DATA_W'(1) << rom_if.rom_addr[1:0]) : '0;

   // Reference rules: modular address walk and the pattern at an address.
   function automatic int nxt(input int a, input logic d);
      return (d == DIR_LEFT) ? (a + 1) % (ADDR_LAST + 1)
                             : (a + ADDR_LAST) % (ADDR_LAST + 1);
   endfunction

   function automatic logic [DATA_W-1:0] pat(input int a);
      return DATA_W'(1 << (a % 4));
   endfunction

   task automatic nclk(input int n);
      repeat (n) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   // Waits (bounded) for the next step_pulse; gap is cycles since last_pulse, -1 on timeout.
   task automatic wait_pulse(input int budget, output int gap);
      gap = -1;
      for (int i = 0; i < budget; i++) begin
         nclk(1);
         if (step_pulse === 1'b1) begin
            gap        = cyc - last_pulse;
            last_pulse = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; run = 1'b0; dir = DIR_LEFT;
      nclk(3);
      checks++; if (rom_if.rom_en !== 1'b0) begin errors++; $display("FAIL reset_rom_en: got %b want 0", rom_if.rom_en); end
      checks++; if (rom_if.rom_addr !== '0) begin errors++; $display("FAIL reset_rom_addr: got %0d want 0", rom_if.rom_addr); end
      checks++; if (led !== '0) begin errors++; $display("FAIL reset_led: got %h want 0", led); end
      checks++; if (step_pulse !== 1'b0) begin errors++; $display("FAIL reset_step_pulse: got %b want 0", step_pulse); end
      rst = 1'b0;
      nclk(4);
      checks++; if (rom_if.rom_en !== 1'b0) begin errors++; $display("FAIL idle_hold_rom_en: got %b want 0", rom_if.rom_en); end
   endtask

   task automatic test_start(input string tag);
      int gap;
      run = 1'b1; dir = DIR_LEFT; last_pulse = cyc; model_addr = 0;
      wait_pulse(4 * STEP, gap);
      checks++; if (gap !== 3) begin errors++; $display("FAIL %s_latency: got %0d want 3", tag, gap); end
      checks++; if (led !== pat(0)) begin errors++; $display("FAIL %s_led: got %h want %h", tag, led, pat(0)); end
      checks++; if (rom_if.rom_addr !== '0) begin errors++; $display("FAIL %s_addr: got %0d want 0", tag, rom_if.rom_addr); end
      nclk(1);
      checks++; if (step_pulse !== 1'b0) begin errors++; $display("FAIL %s_pulse_width: got %b want 0", tag, step_pulse); end
      checks++; if (rom_if.rom_en !== 1'b1) begin errors++; $display("FAIL %s_rom_en: got %b want 1", tag, rom_if.rom_en); end
   endtask

   task automatic test_left;
      int gap;
      dir = DIR_LEFT;
      for (int i = 0; i < 10; i++) begin
         wait_pulse(4 * STEP, gap);
         model_addr = nxt(model_addr, DIR_LEFT);
         checks++; if (gap !== STEP) begin errors++; $display("FAIL left_period[%0d]: got %0d want %0d", i, gap, STEP); end
         checks++; if (rom_if.rom_addr !== ADDR_W'(model_addr)) begin errors++; $display("FAIL left_addr[%0d]: got %0d want %0d", i, rom_if.rom_addr, model_addr); end
         checks++; if (led !== pat(model_addr)) begin errors++; $display("FAIL left_led[%0d]: got %h want %h", i, led, pat(model_addr)); end
      end
   endtask

   task automatic test_right_wrap;
      int gap;
      dir = DIR_RIGHT;
      for (int i = 0; i < 4; i++) begin
         wait_pulse(4 * STEP, gap);
         model_addr = nxt(model_addr, DIR_RIGHT);
         checks++; if (gap !== STEP) begin errors++; $display("FAIL right_period[%0d]: got %0d want %0d", i, gap, STEP); end
         checks++; if (rom_if.rom_addr !== ADDR_W'(model_addr)) begin errors++; $display("FAIL right_addr[%0d]: got %0d want %0d", i, rom_if.rom_addr, model_addr); end
         checks++; if (led !== pat(model_addr)) begin errors++; $display("FAIL right_led[%0d]: got %h want %h", i, led, pat(model_addr)); end
      end
   endtask

   task automatic test_dir_change;
      int gap;
      logic d;
      for (int i = 0; i < 16; i++) begin
         nclk($urandom_range(0, PRESCALE - 1));
         d = ($urandom_range(0, 3) == 0) ? dir : ~dir;
         dir = d;
         wait_pulse(4 * STEP, gap);
         model_addr = nxt(model_addr, d);
         checks++; if (gap !== STEP) begin errors++; $display("FAIL dirchg_period[%0d]: got %0d want %0d", i, gap, STEP); end
         checks++; if (rom_if.rom_addr !== ADDR_W'(model_addr)) begin errors++; $display("FAIL dirchg_addr[%0d]: got %0d want %0d", i, rom_if.rom_addr, model_addr); end
         checks++; if (led !== pat(model_addr)) begin errors++; $display("FAIL dirchg_led[%0d]: got %h want %h", i, led, pat(model_addr)); end
      end
   endtask

   // Counts cycles where the frozen outputs move.
   task automatic hold_and_count(input int n, output int bad);
      bad = 0;
      repeat (n) begin
         nclk(1);
         if (step_pulse !== 1'b0 || led !== pat(model_addr) ||
             rom_if.rom_addr !== ADDR_W'(model_addr) || rom_if.rom_en !== 1'b1)
            bad++;
      end
   endtask

   task automatic test_freeze_tick;
      int gap, bad;
      nclk(PRESCALE - 1);
      run = 1'b0;
      wait_pulse(4 * STEP, gap);
      model_addr = nxt(model_addr, dir);
      checks++; if (gap !== STEP) begin errors++; $display("FAIL freeze_tick_last_step: got %0d want %0d", gap, STEP); end
      checks++; if (rom_if.rom_addr !== ADDR_W'(model_addr)) begin errors++; $display("FAIL freeze_tick_addr: got %0d want %0d", rom_if.rom_addr, model_addr); end
      hold_and_count(20, bad);
      checks++; if (bad !== 0) begin errors++; $display("FAIL freeze_tick_hold: got %0d moving cycles want 0", bad); end
      run = 1'b1; last_pulse = cyc;
      wait_pulse(4 * STEP, gap);
      model_addr = nxt(model_addr, dir);
      checks++; if (gap !== STEP) begin errors++; $display("FAIL freeze_tick_resume: got %0d want %0d", gap, STEP); end
      checks++; if (led !== pat(model_addr)) begin errors++; $display("FAIL freeze_tick_resume_led: got %h want %h", led, pat(model_addr)); end
   endtask

   task automatic test_freeze_mid;
      int gap, bad, k;
      for (int i = 0; i < 4; i++) begin
         k = $urandom_range(0, PRESCALE - 2);
         nclk(k);
         run = 1'b0;
         dir = logic'($urandom_range(0, 1));
         hold_and_count($urandom_range(5, 15), bad);
         checks++; if (bad !== 0) begin errors++; $display("FAIL freeze_mid_hold[%0d]: got %0d moving cycles want 0", i, bad); end
         run = 1'b1; last_pulse = cyc;
         wait_pulse(4 * STEP, gap);
         model_addr = nxt(model_addr, dir);
         checks++; if (gap !== STEP - k) begin errors++; $display("FAIL freeze_mid_resume[%0d]: got %0d want %0d", i, gap, STEP - k); end
         checks++; if (rom_if.rom_addr !== ADDR_W'(model_addr)) begin errors++; $display("FAIL freeze_mid_addr[%0d]: got %0d want %0d", i, rom_if.rom_addr, model_addr); end
      end
   endtask

   task automatic test_reset_capture;
      nclk(PRESCALE + 1);
      rst = 1'b1;
      #1;
      checks++; if (rom_if.rom_en !== 1'b0) begin errors++; $display("FAIL async_rst_rom_en: got %b want 0", rom_if.rom_en); end
      checks++; if (rom_if.rom_addr !== '0) begin errors++; $display("FAIL async_rst_rom_addr: got %0d want 0", rom_if.rom_addr); end
      checks++; if (led !== '0) begin errors++; $display("FAIL async_rst_led: got %h want 0", led); end
      checks++; if (step_pulse !== 1'b0) begin errors++; $display("FAIL async_rst_step_pulse: got %b want 0", step_pulse); end
      run = 1'b0;
      nclk(2);
      rst = 1'b0;
      nclk(3);
      checks++; if (rom_if.rom_en !== 1'b0) begin errors++; $display("FAIL post_rst_idle: got %b want 0", rom_if.rom_en); end
      test_start("restart");
   endtask

   initial begin
      test_reset();
      test_start("start");
      test_left();
      test_right_wrap();
      test_dir_change();
      test_freeze_tick();
      test_freeze_mid();
      test_reset_capture();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
